uart_time_reporter: RTL
=======================

# uart_time_reporter

Serial transmitter that reports a watch/stopwatch time value to a host PC as an ASCII line over UART 8N1. It snapshots the packed 24-bit time bus on a start request, converts each field to two decimal digits and shifts out `HH:MM:SS.CC` plus an optional CR/LF. It is the outbound counterpart of the local 7-segment display path and sits beside the display controller on the same muxed time bus.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000, system clock in Hz.
- `BAUD`, 9600, line rate. `BIT_CYCLES = CLK_FREQ / BAUD` (integer division) clocks per bit.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `i_time`  in  24  packed time: hour[23:19], min[18:13], sec[12:7], centisec[6:0].
- `i_start`  in  1  request pulse; accepted only while `o_busy`=0.
- `o_tx`  out  1  UART line, idle high.
- `o_busy`  out  1  high from acceptance to end of last stop bit.
- `o_done`  out  1  one-cycle pulse when the line completes.

## Operation
- Reset values: `o_tx`=1, `o_busy`=0, `o_done`=0, FSM=IDLE, all counters 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `o_tx`=1. If `i_start`=1, capture `i_time` into the snapshot register, set char index 0, then go to START.
  - START: `o_tx`=0 for `BIT_CYCLES` clocks, then go to DATA.
  - DATA: 8 bits, LSB first, `BIT_CYCLES` each, then go to STOP.
  - STOP: `o_tx`=1 for `BIT_CYCLES` clocks. If more chars remain, advance the index and go to START with no idle gap. Otherwise go to IDLE.
- Character sequence from the snapshot: hour tens, hour ones, `:` (0x3A), min tens, min ones, `:`, sec tens, sec ones, `.` (0x2E), cs tens, cs ones, then 0x0D, 0x0A when CRLF is enabled.
- Digit = 0x30 + value; tens = v/10, ones = v%10, from combinational logic on the snapshot.
- Only the centisec field can exceed 99 (range to 127); values ≥100 clamp to 99. Hour 24–31 and min/sec 60–63 convert literally, e.g. hour 27 sends "27".
- `i_time` changes after capture do not affect the line in progress.
- `i_start` while `o_busy`=1 is ignored and not queued.

## Timing
- `i_start` high at edge N in IDLE: snapshot captured at N; `o_busy`=1 and `o_tx`=0 from N.
- Each bit lasts exactly `BIT_CYCLES` clocks; the baud counter restarts at each bit boundary.
- Each char is 10 bits. `o_busy` stays high for NCHAR×10×`BIT_CYCLES` clocks, where NCHAR is 13 with CRLF and 11 without.
- At the edge ending the final stop bit, `o_busy` falls and `o_done` rises for one cycle. The FSM is in IDLE during that cycle, so an `i_start` in that same cycle is accepted (back-to-back lines).
- Reset during any state returns all outputs to reset values at the next edge; the truncated line is not resumed.

## Configuration
- `UART_TIME_CRLF_EN` defined: 13 chars per line, terminated by 0x0D 0x0A.
- Not defined: 11 chars, no terminator; the char index wraps after the `.` field's ones digit.

## Test plan
Common bench setting: `CLK_FREQ`=1000, `BAUD`=100, giving `BIT_CYCLES`=10; CRLF enabled unless a scenario says otherwise.
- Basic line: `i_time` = 12:34:56.78, pulse `i_start`.
  - The line must decode as 0x31 0x32 0x3A 0x33 0x34 0x3A 0x35 0x36 0x2E 0x37 0x38 0x0D 0x0A.
  - `o_busy` must stay high for exactly 1300 clocks; `o_done` must pulse once.
- Snapshot and clamp: `i_time` = 00:00:00 with cs=127, start, then change `i_time` one cycle later.
  - Line must read "00:00:00.99\r\n" and be unaffected by the change.
- Busy ignore: pulse `i_start` again at cycle 50 and at cycle 700 of a line.
  - Exactly one line is sent; `o_done` pulses once.
- Back-to-back: assert `i_start` in the `o_done` cycle.
  - The next start bit begins with no idle bit between lines; two complete lines are received.
- Reset mid-char: assert `reset` at cycle 235.
  - Next edge: `o_tx`=1, `o_busy`=0, `o_done`=0; the line stays idle-high until a new `i_start`.
- CRLF disabled: repeat the basic-line scenario without `UART_TIME_CRLF_EN`.
  - 11 chars are sent; `o_busy` stays high for 1100 clocks.

Source files
------------

// File: rtl/uart_time_reporter.sv
// UART 8N1 transmitter that snapshots a packed time bus and sends "HH:MM:SS.CC" as ASCII digits.
// Define UART_TIME_CRLF_EN to terminate each line with CR LF (13 chars instead of 11).
module uart_time_reporter #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] i_time,
  input  logic        i_start,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_done
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
`ifdef UART_TIME_CRLF_EN
  localparam logic [3:0] LAST_IDX = 4'd12;
`else
  localparam logic [3:0] LAST_IDX = 4'd10;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [3:0]       char_idx;
  logic [23:0]      snap;
  logic [6:0]       cs_clamped;
  logic [7:0]       cur_char;

  function automatic logic [7:0] tens_ch(input logic [6:0] v);
    return 8'h30 + 8'(v / 7'd10);
  endfunction

  function automatic logic [7:0] ones_ch(input logic [6:0] v);
    return 8'h30 + 8'(v % 7'd10);
  endfunction

  // Only centiseconds can exceed two digits; hours/min/sec convert literally.
  assign cs_clamped = (snap[6:0] > 7'd99) ? 7'd99 : snap[6:0];

  always_comb begin
    cur_char = 8'h20;
    case (char_idx)
      4'd0:  cur_char = tens_ch({2'b00, snap[23:19]});
      4'd1:  cur_char = ones_ch({2'b00, snap[23:19]});
      4'd2:  cur_char = 8'h3A;
      4'd3:  cur_char = tens_ch({1'b0, snap[18:13]});
      4'd4:  cur_char = ones_ch({1'b0, snap[18:13]});
      4'd5:  cur_char = 8'h3A;
      4'd6:  cur_char = tens_ch({1'b0, snap[12:7]});
      4'd7:  cur_char = ones_ch({1'b0, snap[12:7]});
      4'd8:  cur_char = 8'h2E;
      4'd9:  cur_char = tens_ch(cs_clamped);
      4'd10: cur_char = ones_ch(cs_clamped);
`ifdef UART_TIME_CRLF_EN
      4'd11: cur_char = 8'h0D;
      4'd12: cur_char = 8'h0A;
`endif
      default: cur_char = 8'h20;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      snap     <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            snap     <= i_time;
            char_idx <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            o_tx     <= 1'b0;
            o_busy   <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            o_tx     <= cur_char[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              o_tx  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              o_tx    <= cur_char[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (char_idx == LAST_IDX) begin
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= IDLE;
            end else begin
              // Next start bit follows the stop bit directly, no idle gap.
              char_idx <= char_idx + 4'd1;
              o_tx     <= 1'b0;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
